// File: rtl/phy_init_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// phy_init_sequencer
//
// Purpose:
//   Takes an Ethernet PHY from power-up to link-up in the init_clk domain.
//   The sequence is:
//     1. Hold the PHY hardware reset.
//     2. Release it and let the PHY settle.
//     3. Write BMCR (reg 0) over MDIO.
//     4. Poll BMSR (reg 1) until bit2 (link status) reads 1.
//   The datapath enable out_en is high only while the link is up. Polling
//   continues in LINK_UP, and a failed read drops out_en again.
//
// Build option:
//   PHY_INIT_LOOPBACK_EN - adds input cfg_loopback, which drives BMCR bit14.
//                          When undefined, the port is absent and bit14 is 0.
//
// Ports:
//   init_clk      in   clock (10 kHz)
//   reset         in   asynchronous, active-high
//   restart       in   1-cycle pulse, re-runs the whole sequence
//   cfg_speed100  in   BMCR bit13, sampled on entry to the BMCR write
//   cfg_full_dup  in   BMCR bit8,  sampled on entry to the BMCR write
//   cfg_autoneg   in   BMCR bit12 and bit9, sampled on entry to the BMCR write
//   cfg_loopback  in   BMCR bit14 (only with PHY_INIT_LOOPBACK_EN)
//   mdio_i        in   MDIO pad input
//   phy_reset     out  PHY hardware reset, active-low
//   mdc           out  MDIO clock (init_clk/2 during frames, else 0)
//   mdio_o        out  MDIO pad output
//   mdio_oe       out  MDIO pad output enable
//   out_en        out  datapath enable
//   init_done     out  sticky, set when the first BMCR write completes
//   link_err      out  set after LINK_TIMEOUT consecutive link-down polls
//   state_o       out  current FSM state (debug)
// -----------------------------------------------------------------------------
module phy_init_sequencer #(
    parameter int         RST_LOW_CYCLES  = 100,
    parameter int         RST_WAIT_CYCLES = 25,
    parameter int         POLL_INTERVAL   = 50,
    parameter int         LINK_TIMEOUT    = 40,
    parameter logic [4:0] PHY_ADDR        = 5'h01
) (
    input  logic       init_clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       cfg_speed100,
    input  logic       cfg_full_dup,
    input  logic       cfg_autoneg,
`ifdef PHY_INIT_LOOPBACK_EN
    input  logic       cfg_loopback,
`endif
    input  logic       mdio_i,
    output logic       phy_reset,
    output logic       mdc,
    output logic       mdio_o,
    output logic       mdio_oe,
    output logic       out_en,
    output logic       init_done,
    output logic       link_err,
    output logic [2:0] state_o
);

    localparam logic [2:0] S_RST_ASSERT = 3'd0;
    localparam logic [2:0] S_RST_WAIT   = 3'd1;
    localparam logic [2:0] S_MDIO_WR    = 3'd2;
    localparam logic [2:0] S_POLL_WAIT  = 3'd3;
    localparam logic [2:0] S_MDIO_RD    = 3'd4;
    localparam logic [2:0] S_LINK_UP    = 3'd5;

    // One shared wait counter, sized for the longest of the wait intervals.
    localparam int MAX_A    = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
    localparam int MAX_WAIT = (MAX_A > POLL_INTERVAL) ? MAX_A : POLL_INTERVAL;
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam int TO_W     = $clog2(LINK_TIMEOUT + 1);

    localparam logic [WAIT_W-1:0] RST_LOW_LAST  = WAIT_W'(RST_LOW_CYCLES - 1);
    localparam logic [WAIT_W-1:0] RST_WAIT_LAST = WAIT_W'(RST_WAIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] POLL_LAST     = WAIT_W'(POLL_INTERVAL - 1);
    localparam logic [TO_W-1:0]   TO_MAX        = TO_W'(LINK_TIMEOUT);

    // A frame is 64 bits, 2 half-cycles each. Even halves drive mdc=0,
    // odd halves drive mdc=1.
    localparam logic [6:0] FRAME_LAST    = 7'd127;
    // BMSR bit2 is frame bit 61 (data starts at bit 48, MSB first).
    // It is sampled at the end of that bit's mdc-high half.
    localparam logic [6:0] LINK_BIT_HALF = 7'd123;

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [6:0]        frame_cnt_q, frame_cnt_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;
    logic [15:0]       bmcr_q, bmcr_d;
    logic              link_bit_q, link_bit_d;
    logic              phy_reset_q, phy_reset_d;
    logic              mdc_q, mdc_d;
    logic              mdio_o_q, mdio_o_d;
    logic              mdio_oe_q, mdio_oe_d;
    logic              out_en_q, out_en_d;
    logic              init_done_q, init_done_d;
    logic              link_err_q, link_err_d;

    logic              loopback_bit;
    logic [15:0]       bmcr_cfg;
    logic [6:0]        next_half;
    logic              frame_is_wr;

`ifdef PHY_INIT_LOOPBACK_EN
    assign loopback_bit = cfg_loopback;
`else
    assign loopback_bit = 1'b0;
`endif

    assign bmcr_cfg = {1'b0, loopback_bit, cfg_speed100, cfg_autoneg, 2'b00,
                       cfg_autoneg, cfg_full_dup, 8'h00};

    // Value driven on mdio_o for frame bit idx (0 = first preamble bit).
    // For reads, TA and data are not driven; the pad sits at 1.
    function automatic logic frame_bit(input logic [5:0] idx, input logic is_wr,
                                       input logic [15:0] data);
        logic [63:0] f;
        f = {32'hFFFF_FFFF, 2'b01, (is_wr ? 2'b01 : 2'b10), PHY_ADDR,
             (is_wr ? 5'd0 : 5'd1), (is_wr ? 2'b10 : 2'b11),
             (is_wr ? data : 16'hFFFF)};
        return f[6'd63 - idx];
    endfunction

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        frame_cnt_d = frame_cnt_q;
        timeout_d   = timeout_q;
        bmcr_d      = bmcr_q;
        link_bit_d  = link_bit_q;
        phy_reset_d = phy_reset_q;
        mdc_d       = mdc_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        out_en_d    = out_en_q;
        init_done_d = init_done_q;
        link_err_d  = link_err_q;
        next_half   = frame_cnt_q + 7'd1;
        frame_is_wr = (state_q == S_MDIO_WR);

        case (state_q)
            S_RST_ASSERT: begin
                if (wait_cnt_q == RST_LOW_LAST) begin
                    phy_reset_d = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = S_RST_WAIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_RST_WAIT: begin
                if (wait_cnt_q == RST_WAIT_LAST) begin
                    // Configuration is frozen here for the whole write frame.
                    bmcr_d      = bmcr_cfg;
                    wait_cnt_d  = '0;
                    frame_cnt_d = '0;
                    mdc_d       = 1'b0;
                    mdio_oe_d   = 1'b1;
                    mdio_o_d    = frame_bit(6'd0, 1'b1, bmcr_cfg);
                    state_d     = S_MDIO_WR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_MDIO_WR, S_MDIO_RD: begin
                if (frame_cnt_q == FRAME_LAST) begin
                    mdc_d       = 1'b0;
                    mdio_oe_d   = 1'b0;
                    mdio_o_d    = 1'b1;
                    frame_cnt_d = '0;
                    if (frame_is_wr) begin
                        init_done_d = 1'b1;
                        state_d     = S_POLL_WAIT;
                    end else if (link_bit_q) begin
                        out_en_d   = 1'b1;
                        timeout_d  = '0;
                        link_err_d = 1'b0;
                        state_d    = S_LINK_UP;
                    end else begin
                        out_en_d = 1'b0;
                        if (timeout_q != TO_MAX) begin
                            timeout_d = timeout_q + 1'b1;
                        end
                        link_err_d = link_err_q | (timeout_d == TO_MAX);
                        state_d    = S_POLL_WAIT;
                    end
                end else begin
                    // Outputs are registered for the half that starts next.
                    frame_cnt_d = next_half;
                    mdc_d       = next_half[0];
                    mdio_o_d    = frame_bit(next_half[6:1], frame_is_wr, bmcr_q);
                    // Reads release the pad from the TA bits (bit 46) onward.
                    mdio_oe_d   = frame_is_wr | (next_half[6:1] < 6'd46);
                    if (!frame_is_wr && frame_cnt_q == LINK_BIT_HALF) begin
                        link_bit_d = mdio_i;
                    end
                end
            end

            S_POLL_WAIT, S_LINK_UP: begin
                if (wait_cnt_q == POLL_LAST) begin
                    wait_cnt_d  = '0;
                    frame_cnt_d = '0;
                    link_bit_d  = 1'b0;
                    mdc_d       = 1'b0;
                    mdio_oe_d   = 1'b1;
                    mdio_o_d    = frame_bit(6'd0, 1'b0, bmcr_q);
                    state_d     = S_MDIO_RD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_RST_ASSERT;
            end
        endcase

        // restart abandons any frame in flight; init_done survives it.
        if (restart) begin
            state_d     = S_RST_ASSERT;
            wait_cnt_d  = '0;
            frame_cnt_d = '0;
            phy_reset_d = 1'b0;
            out_en_d    = 1'b0;
            mdio_oe_d   = 1'b0;
            mdc_d       = 1'b0;
            mdio_o_d    = 1'b1;
        end
    end

    always_ff @(posedge init_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RST_ASSERT;
            wait_cnt_q  <= '0;
            frame_cnt_q <= '0;
            timeout_q   <= '0;
            bmcr_q      <= '0;
            link_bit_q  <= 1'b0;
            phy_reset_q <= 1'b0;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            out_en_q    <= 1'b0;
            init_done_q <= 1'b0;
            link_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            timeout_q   <= timeout_d;
            bmcr_q      <= bmcr_d;
            link_bit_q  <= link_bit_d;
            phy_reset_q <= phy_reset_d;
            mdc_q       <= mdc_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            out_en_q    <= out_en_d;
            init_done_q <= init_done_d;
            link_err_q  <= link_err_d;
        end
    end

    assign phy_reset = phy_reset_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign out_en    = out_en_q;
    assign init_done = init_done_q;
    assign link_err  = link_err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_phy_init_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_phy_init_sequencer
//
// Purpose:
//   Drives phy_init_sequencer through a full sequence:
//     - power-up reset
//     - the BMCR write
//     - link-up, link-down and timeout polls
//     - a restart in the middle of a frame
//   A PHY model answers BMSR reads. A frame monitor collects each MDIO frame.
//   Expected frames and link flags come from a reference model written
//   directly from the protocol rules.
//
// Build option:
//   PHY_INIT_LOOPBACK_EN - drives cfg_loopback and expects BMCR bit14.
// -----------------------------------------------------------------------------
module tb_phy_init_sequencer;

    localparam int         RST_LOW  = 4;
    localparam int         RST_WAIT = 2;
    localparam int         POLL     = 3;
    localparam int         TMO      = 2;
    localparam logic [4:0] ADDR     = 5'h01;

    logic       init_clk = 1'b0;
    logic       reset;
    logic       restart;
    logic       cfg_speed100;
    logic       cfg_full_dup;
    logic       cfg_autoneg;
    logic       cfg_lb;
`ifdef PHY_INIT_LOOPBACK_EN
    logic       cfg_loopback;
`endif
    logic       mdio_i = 1'b1;
    logic       phy_reset;
    logic       mdc;
    logic       mdio_o;
    logic       mdio_oe;
    logic       out_en;
    logic       init_done;
    logic       link_err;
    logic [2:0] state_o;

    phy_init_sequencer #(
        .RST_LOW_CYCLES  (RST_LOW),
        .RST_WAIT_CYCLES (RST_WAIT),
        .POLL_INTERVAL   (POLL),
        .LINK_TIMEOUT    (TMO),
        .PHY_ADDR        (ADDR)
    ) dut (
        .init_clk     (init_clk),
        .reset        (reset),
        .restart      (restart),
        .cfg_speed100 (cfg_speed100),
        .cfg_full_dup (cfg_full_dup),
        .cfg_autoneg  (cfg_autoneg),
`ifdef PHY_INIT_LOOPBACK_EN
        .cfg_loopback (cfg_loopback),
`endif
        .mdio_i       (mdio_i),
        .phy_reset    (phy_reset),
        .mdc          (mdc),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .out_en       (out_en),
        .init_done    (init_done),
        .link_err     (link_err),
        .state_o      (state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #50 init_clk = ~init_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

`ifdef PHY_INIT_LOOPBACK_EN
    always_comb cfg_loopback = cfg_lb;
`endif

    // ---------------- bookkeeping ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic        exp_rd_q[$];

    // Reference link model: out_en, link_err and the consecutive-fail count.
    int          m_fail = 0;
    logic        m_en   = 1'b0;
    logic        m_err  = 1'b0;

    // ---------------- PHY model + frame monitor ----------------
    logic [15:0] phy_bmsr = 16'h0004;
    int          mon_idx  = 0;
    logic        mon_prev_mdc = 1'b0;
    logic [63:0] mon_bits;
    logic [63:0] mon_oe;
    logic [63:0] frm_q[$];
    logic [63:0] oe_q[$];

    // Each mdc-high half is one frame bit. The PHY puts read data on mdio_i
    // here, ahead of the rising init_clk edge that samples it. Two idle mdc
    // samples in a row mean no frame is in progress.
    always @(negedge init_clk) begin
        if (reset) begin
            mon_idx = 0;
            mdio_i  = 1'b1;
        end else if (mdc) begin
            mon_bits[63 - mon_idx] = mdio_o;
            mon_oe[63 - mon_idx]   = mdio_oe;
            if (mon_idx >= 48) mdio_i = phy_bmsr[15 - (mon_idx - 48)];
            else               mdio_i = 1'b1;
            if (mon_idx == 63) begin
                frm_q.push_back(mon_bits);
                oe_q.push_back(mon_oe);
                mon_idx = 0;
            end else begin
                mon_idx++;
            end
        end else if (!mon_prev_mdc) begin
            mon_idx = 0;
        end
        mon_prev_mdc = mdc;
    end

    // ---------------- reference functions ----------------
    function automatic logic [63:0] exp_wr_frame(input logic spd, input logic dup,
                                                 input logic an, input logic lb);
        logic [15:0] bmcr;
        bmcr     = 16'h0000;
        bmcr[14] = lb;
        bmcr[13] = spd;
        bmcr[12] = an;
        bmcr[9]  = an;
        bmcr[8]  = dup;
        return {32'hFFFF_FFFF, 2'b01, 2'b01, ADDR, 5'd0, 2'b10, bmcr};
    endfunction

    function automatic logic [63:0] exp_rd_frame();
        return {32'hFFFF_FFFF, 2'b01, 2'b10, ADDR, 5'd1, 18'h0};
    endfunction

    task automatic model_read(input logic [15:0] bmsr);
        if (bmsr[2]) begin
            m_fail = 0;
            m_en   = 1'b1;
            m_err  = 1'b0;
        end else begin
            m_en = 1'b0;
            if (m_fail < TMO) m_fail++;
            if (m_fail >= TMO) m_err = 1'b1;
        end
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic wait_neg();
        @(negedge init_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_frame(output logic [63:0] f, output logic [63:0] m);
        int n = 0;
        while (frm_q.size() == 0 && n < 3000) begin
            wait_neg();
            n++;
        end
        check("frame_arrived", 64'(frm_q.size() != 0), 64'd1);
        if (frm_q.size() != 0) begin
            f = frm_q.pop_front();
            m = oe_q.pop_front();
        end else begin
            f = '0;
            m = '0;
        end
    endtask

    // Compares the next monitored frame against the scoreboard head.
    // Read frames are compared over the 46 driven bits only.
    task automatic check_frame(input string tag, output logic [63:0] f_out);
        logic [63:0] f, m, e, mask;
        logic        is_rd;
        wait_frame(f, m);
        e     = exp_q.pop_front();
        is_rd = exp_rd_q.pop_front();
        mask  = is_rd ? {{46{1'b1}}, 18'h0} : {64{1'b1}};
        check({tag, "_bits"}, f & mask, e & mask);
        check({tag, "_oe"}, m, mask);
        f_out = f;
    endtask

    task automatic count_reset_and_settle(input string tag);
        int n_low  = 0;
        int n_wait = 0;
        int n      = 0;
        while (phy_reset === 1'b0 && n < 200) begin
            n_low++;
            n++;
            wait_neg();
        end
        check({tag, "_phy_reset_low_cycles"}, 64'(n_low), 64'(RST_LOW));
        n = 0;
        while (mdio_oe !== 1'b1 && n < 200) begin
            n_wait++;
            n++;
            wait_neg();
        end
        check({tag, "_settle_cycles"}, 64'(n_wait), 64'(RST_WAIT));
    endtask

    task automatic do_read(input string tag, input logic [15:0] bmsr);
        logic [63:0] f;
        phy_bmsr = bmsr;
        exp_q.push_back(exp_rd_frame());
        exp_rd_q.push_back(1'b1);
        check_frame(tag, f);
        model_read(bmsr);
        wait_neg();
        check({tag, "_out_en"}, 64'(out_en), 64'(m_en));
        check({tag, "_link_err"}, 64'(link_err), 64'(m_err));
        check({tag, "_idle_oe"}, 64'(mdio_oe), 64'd0);
    endtask

    task automatic do_write(input string tag);
        logic [63:0] f;
        exp_q.push_back(exp_wr_frame(cfg_speed100, cfg_full_dup, cfg_autoneg, cfg_lb));
        exp_rd_q.push_back(1'b0);
        check_frame(tag, f);
        wait_neg();
        check({tag, "_init_done"}, 64'(init_done), 64'd1);
        check({tag, "_idle_mdc"}, 64'(mdc), 64'd0);
        check({tag, "_idle_mdio_o"}, 64'(mdio_o), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] f;
        logic [15:0] bmsr;
        int          n;

        reset        = 1'b1;
        restart      = 1'b0;
        cfg_speed100 = 1'b1;
        cfg_full_dup = 1'b1;
        cfg_autoneg  = 1'b0;
`ifdef PHY_INIT_LOOPBACK_EN
        cfg_lb = 1'b1;
`else
        cfg_lb = 1'b0;
`endif
        repeat (3) wait_neg();

        // Reset state
        check("rst_phy_reset", 64'(phy_reset), 64'd0);
        check("rst_mdc",       64'(mdc),       64'd0);
        check("rst_mdio_o",    64'(mdio_o),    64'd1);
        check("rst_mdio_oe",   64'(mdio_oe),   64'd0);
        check("rst_out_en",    64'(out_en),    64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_link_err",  64'(link_err),  64'd0);

        reset = 1'b0;
        count_reset_and_settle("boot");

        // First BMCR write. For spd=1, dup=1, an=0 the data field is
        // 16'h2100, or 16'h6100 when loopback is also set.
        exp_q.push_back(exp_wr_frame(cfg_speed100, cfg_full_dup, cfg_autoneg, cfg_lb));
        exp_rd_q.push_back(1'b0);
        check_frame("wr0", f);
`ifdef PHY_INIT_LOOPBACK_EN
        check("wr0_bmcr", 64'(f[15:0]), 64'h6100);
`else
        check("wr0_bmcr", 64'(f[15:0]), 64'h2100);
`endif
        check("wr0_init_done_before_end", 64'(init_done), 64'd0);
        wait_neg();
        check("wr0_init_done", 64'(init_done), 64'd1);
        check("wr0_idle_mdc",  64'(mdc),       64'd0);
        check("wr0_idle_oe",   64'(mdio_oe),   64'd0);

        // Link up, down twice (timeout), and up again
        do_read("rd_up0",   16'h0004);
        do_read("rd_down1", 16'h0000);
        do_read("rd_down2", 16'h0000);
        do_read("rd_up1",   16'h0004);

        // Random BMSR values
        for (int i = 0; i < 10; i++) begin
            bmsr    = 16'($urandom);
            bmsr[2] = ($urandom_range(0, 2) == 0);
            do_read($sformatf("rd_rand%0d", i), bmsr);
        end

        // Restart in the middle of a read frame
        phy_bmsr = 16'($urandom);
        n = 0;
        while (mon_idx < 50 && n < 1000) begin
            wait_neg();
            n++;
        end
        check("restart_reached_mid_frame", 64'(mon_idx >= 50), 64'd1);
        restart = 1'b1;
        wait_neg();
        restart      = 1'b0;
        cfg_speed100 = 1'($urandom_range(0, 1));
        cfg_full_dup = 1'($urandom_range(0, 1));
        cfg_autoneg  = 1'($urandom_range(0, 1));
`ifdef PHY_INIT_LOOPBACK_EN
        cfg_lb = 1'($urandom_range(0, 1));
`endif
        check("restart_mdc",       64'(mdc),       64'd0);
        check("restart_mdio_oe",   64'(mdio_oe),   64'd0);
        check("restart_phy_reset", 64'(phy_reset), 64'd0);
        check("restart_out_en",    64'(out_en),    64'd0);
        check("restart_init_done", 64'(init_done), 64'd1);
        m_en = 1'b0;

        count_reset_and_settle("restart");
        do_write("wr1");
        do_read("rd_after_restart", 16'h0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
